instr_encoder_loader: RTL and testbench

- Instruction encoder and program loader for the single-cycle and pipelined MIPS cores: the encode direction of the main control decoder.
- Accepts field-level instruction descriptions over a valid/ready handshake and assembles 32-bit machine words for the decoder's supported set: R-type, ADDI, BEQ, J, JAL, SW, LW.
- Writes the words sequentially into instruction memory, starting at word 0, during a load session bracketed by start/finish.
- Used by benches and the boot path to fill imem before the core is released.

---
 rtl/instr_encoder_loader.sv | 164 ++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Assembles MIPS words from field descriptions and writes them sequentially into imem; one-cycle latency handshake->write.
// Backpressure: in_ready_o drops outside an open session and when imem is full; held-off fields are not consumed.
module instr_encoder_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              finish_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              busy_o,
    output logic              full_o,
    output logic              err_o,
    output logic              load_done_o
);

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [2:0]      KIND_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FULL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                full_q, full_d;
    logic                done_q, done_d;
    logic                hs;

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        w = 32'h0;
        case (kind)
            3'd0:    w = {6'b000000, rs, rt, rd, shamt, funct};
            3'd1:    w = {6'b001000, rs, rt, imm};
            3'd2:    w = {6'b000100, rs, rt, imm};
            3'd3:    w = {6'b000010, target};
            3'd4:    w = {6'b000011, target};
            3'd5:    w = {6'b101011, rs, rt, imm};
            3'd6:    w = {6'b100011, rs, rt, imm};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // ready_q is only ever set while in LOAD, so it alone qualifies the handshake
    assign hs = in_valid_i & ready_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    if (kind_i == KIND_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = encode(kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i);
                        count_d = count_q + 1'b1;
                    end
                end
                if (finish_i) begin
                    state_d = S_DONE;
                end else if (count_d == CAP) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (finish_i) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Status outputs are registered copies of what the next state implies
        ready_d = (state_d == S_LOAD);
        busy_d  = (state_d == S_LOAD) || (state_d == S_FULL);
        full_d  = (count_d == CAP);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            full_q  <= full_d;
            done_q  <= done_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign im_we_o     = we_q;
    assign im_addr_o   = addr_q;
    assign im_wdata_o  = wdata_q;
    assign count_o     = count_q;
    assign busy_o      = busy_q;
    assign full_o      = full_q;
    assign err_o       = err_q;
    assign load_done_o = done_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader at a 4-word imem: directed literal cases plus randomized sessions
// checked every cycle against a session-level reference model.
module tb_instr_encoder_loader;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, start, finish, in_valid;
    logic [2:0]    kind;
    logic [4:0]    rs, rt, rd, shamt;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          in_ready, im_we, busy, full, err, load_done;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .finish_i(finish),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .kind_i(kind),
        .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
        .imm_i(imm), .target_i(target), .im_we_o(im_we), .im_addr_o(im_addr),
        .im_wdata_o(im_wdata), .count_o(count), .busy_o(busy), .full_o(full),
        .err_o(err), .load_done_o(load_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] k, input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] c, input logic [4:0] s, input logic [5:0] f,
                                        input logic [15:0] i, input logic [25:0] t);
        logic [5:0] opc [7];
        opc = '{6'h00, 6'h08, 6'h04, 6'h02, 6'h03, 6'h2B, 6'h23};
        if (k == 3'd3 || k == 3'd4) return {opc[k], t};
        if (k == 3'd0)              return {opc[0], a, b, c, s, f};
        return {opc[k], a, b, i};
    endfunction

    // Reference model: a session is open or closing; count, sticky err and the last write
    bit          m_open = 0, m_done = 0, m_err = 0, m_we = 0;
    int          m_cnt = 0, m_addr = 0;
    logic [31:0] m_wdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_open = 0; m_done = 0; m_cnt = 0; m_err = 0;
            m_we = 0; m_addr = 0; m_wdata = '0;
        end else begin
            m_we = 0;
            if (m_done) begin
                m_done = 0;
            end else if (!m_open) begin
                if (start) begin
                    m_open = 1; m_cnt = 0; m_err = 0;
                end
            end else begin
                if (in_valid && m_cnt < CAP) begin
                    if (kind == 3'd7) begin
                        m_err = 1;
                    end else begin
                        m_we = 1; m_addr = m_cnt;
                        m_wdata = enc(kind, rs, rt, rd, shamt, funct, imm, target);
                        m_cnt++;
                    end
                end
                if (finish) begin
                    m_open = 0; m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  32'(in_ready),  32'(m_open && m_cnt < CAP));
        chk("im_we",     32'(im_we),     32'(m_we));
        chk("im_addr",   32'(im_addr),   32'(m_addr));
        chk("im_wdata",  im_wdata,       m_wdata);
        chk("count",     32'(count),     32'(m_cnt));
        chk("busy",      32'(busy),      32'(m_open));
        chk("full",      32'(full),      32'(m_cnt == CAP));
        chk("err",       32'(err),       32'(m_err));
        chk("load_done", 32'(load_done), 32'(m_done));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic put(input logic [2:0] k, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic [4:0] s, input logic [5:0] f, input logic [15:0] i, input logic [25:0] t);
        in_valid = 1'b1; kind = k; rs = a; rt = b; rd = c; shamt = s; funct = f; imm = i; target = t;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; kind = '0;
        rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; target = '0;
        tick(); tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();

        start = 1'b1; tick(); start = 1'b0;
        chk("start_ready", 32'(in_ready), 32'd1);
        put(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0); tick(); in_valid = 1'b0;
        chk("addi_we", 32'(im_we), 32'd1);
        chk("addi_addr", 32'(im_addr), 32'd0);
        chk("addi_word", im_wdata, 32'h20080005);
        chk("addi_count", 32'(count), 32'd1);
        put(3'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'd0, 26'd0); tick();
        chk("rtype_word", im_wdata, 32'h01095020);
        chk("rtype_addr", 32'(im_addr), 32'd1);
        put(3'd6, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0); tick();
        chk("lw_we", 32'(im_we), 32'd1);
        chk("lw_word", im_wdata, 32'h8FA80004);
        chk("lw_addr", 32'(im_addr), 32'd2);
        put(3'd2, 5'd8, 5'd0, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0); tick();
        chk("beq_word", im_wdata, 32'h1100FFFF);
        chk("beq_addr", 32'(im_addr), 32'd3);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_ready", 32'(in_ready), 32'd0);
        put(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd7, 26'd0); tick();
        chk("held_we", 32'(im_we), 32'd0);
        tick();
        chk("held_count", 32'(count), 32'd4);
        in_valid = 1'b0; finish = 1'b1; tick(); finish = 1'b0;
        chk("done_pulse", 32'(load_done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_count", 32'(count), 32'd4);
        tick();
        chk("done_once", 32'(load_done), 32'd0);

        start = 1'b1; tick(); start = 1'b0;
        put(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010); tick();
        chk("jal_word", im_wdata, 32'h0C000010);
        put(3'd7, 5'd3, 5'd3, 5'd3, 5'd3, 6'd3, 16'd3, 26'd3); tick();
        chk("ill_we", 32'(im_we), 32'd0);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_count", 32'(count), 32'd1);
        put(3'd5, 5'd29, 5'd9, 5'd0, 5'd0, 6'd0, 16'd8, 26'd0); tick(); in_valid = 1'b0;
        chk("sw_word", im_wdata, 32'hAFA90008);
        chk("sw_addr", 32'(im_addr), 32'd1);
        finish = 1'b1; tick(); finish = 1'b0; tick();
        chk("err_sticky", 32'(err), 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        chk("err_clear", 32'(err), 32'd0);
        put(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0); rst = 1'b1; tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_drop_we", 32'(im_we), 32'd0);
        chk("rst_count0", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        put(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0); finish = 1'b1; tick();
        finish = 1'b0; in_valid = 1'b0;
        chk("fin_hs_we", 32'(im_we), 32'd1);
        chk("fin_hs_addr", 32'(im_addr), 32'd0);
        chk("fin_hs_done", 32'(load_done), 32'd1);
        tick();

        for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 5) == 0);
            finish   = ($urandom_range(0, 11) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            kind     = 3'($urandom);
            rs       = 5'($urandom);
            rt       = 5'($urandom);
            rd       = 5'($urandom);
            shamt    = 5'($urandom);
            funct    = 6'($urandom);
            imm      = 16'($urandom);
            target   = 26'($urandom);
            tick();
        end
        rst = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
